// File: rtl/winograd_pkg.sv
// Shared constants and state encoding for the Winograd F(2x2,3x3) input path.
package winograd_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int TILE       = 4;
    localparam int STRIDE     = 2;
    localparam int OUT_TILE   = 2;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } feeder_state_t;
endpackage

// File: rtl/wino_line_buffer.sv
// Four-row circular line buffer: single pixel write, four-row column read rotated by base slot.
module wino_line_buffer
    import winograd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 8,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [1:0]                   wr_slot,
    input  logic [COL_W-1:0]             wr_col,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [COL_W-1:0]             rd_col,
    input  logic [1:0]                   rd_base,
    output logic [TILE-1:0][DATA_W-1:0]  rd_data
);
    logic [DATA_W-1:0] mem_reg [TILE][IMG_W];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_slot][wr_col] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < TILE; gi++) begin : g_rd
            logic [1:0] slot;
            assign slot        = rd_base + 2'(gi);
            assign rd_data[gi] = mem_reg[slot][rd_col];
        end
    endgenerate
endmodule

// File: rtl/winograd_tile_feeder.sv
// Raster pixel stream to overlapping 4x4 stride-2 tiles, emitted one 4-row column per cycle.
module winograd_tile_feeder
    import winograd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_pix,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] r1_x,
    output logic signed [DATA_W-1:0] r2_x,
    output logic signed [DATA_W-1:0] r3_x,
    output logic signed [DATA_W-1:0] r4_x,
    output logic                     out_valid,
    output logic                     tile_start,
    output logic [1:0]               out_col,
    output logic                     frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int NT    = (IMG_W - 2) / STRIDE;
    localparam int NB    = (IMG_H - 2) / STRIDE;

    feeder_state_t              state_reg, state_next;
    logic [COL_W-1:0]           col_reg, col_next;
    logic [ROW_W-1:0]           row_reg, row_next;
    logic [ROW_W-1:0]           band_reg, band_next;
    logic [1:0]                 base_reg, base_next;
    logic [COL_W-1:0]           tile_reg, tile_next;
    logic [1:0]                 k_reg, k_next;
    logic                       in_ready_reg, in_ready_next;
    logic                       out_valid_reg, out_valid_next;
    logic                       tile_start_reg, tile_start_next;
    logic                       frame_done_reg, frame_done_next;
    logic [TILE-1:0][DATA_W-1:0] data_reg, data_next, rd_data;

    logic             accept;
    logic             last_pix;
    logic             load;
    logic [COL_W-1:0] rd_col;
    logic [ROW_W-1:0] need_row;

    wino_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .COL_W  (COL_W)
    ) u_lb (
        .clk     (clk),
        .wr_en   (accept),
        .wr_slot (row_reg[1:0]),
        .wr_col  (col_reg),
        .wr_data (in_pix),
        .rd_col  (rd_col),
        .rd_base (base_reg),
        .rd_data (rd_data)
    );

    // Bottom row of band b is 2b+3; its last pixel releases the band.
    assign need_row  = ROW_W'(int'(band_reg) * STRIDE + TILE - 1);
    assign data_next = load ? rd_data : data_reg;

    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        band_next       = band_reg;
        base_next       = base_reg;
        tile_next       = tile_reg;
        k_next          = k_reg;
        in_ready_next   = in_ready_reg;
        out_valid_next  = 1'b0;
        tile_start_next = 1'b0;
        frame_done_next = 1'b0;
        load            = 1'b0;
        rd_col          = '0;
        accept          = in_valid && in_ready_reg && (state_reg == FILL);
        last_pix        = accept && (col_reg == COL_W'(IMG_W - 1)) && (row_reg == need_row);

        case (state_reg)
            FILL: begin
                in_ready_next = 1'b1;
                if (accept) begin
                    if (col_reg == COL_W'(IMG_W - 1)) begin
                        col_next = '0;
                        row_next = (row_reg == ROW_W'(IMG_H - 1)) ? '0 : row_reg + ROW_W'(1);
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                end
                // Column 0 is loaded on the same edge so the band starts with no bubble.
                if (last_pix) begin
                    state_next    = EMIT;
                    in_ready_next = 1'b0;
                    load          = 1'b1;
                    tile_next     = '0;
                    k_next        = '0;
                end
            end
            EMIT: begin
                in_ready_next = 1'b0;
                if (k_reg == 2'(TILE - 1) && tile_reg == COL_W'(NT - 1)) begin
                    state_next    = FILL;
                    in_ready_next = 1'b1;
                    if (band_reg == ROW_W'(NB - 1)) begin
                        frame_done_next = 1'b1;
                        band_next       = '0;
                        base_next       = '0;
                        row_next        = '0;
                        col_next        = '0;
                    end else begin
                        band_next = band_reg + ROW_W'(1);
                        base_next = base_reg + 2'(STRIDE);
                    end
                end else begin
                    load = 1'b1;
                    if (k_reg == 2'(TILE - 1)) begin
                        tile_next = tile_reg + COL_W'(1);
                        k_next    = '0;
                    end else begin
                        k_next = k_reg + 2'd1;
                    end
                end
            end
            default: state_next = FILL;
        endcase

        if (load) begin
            rd_col          = COL_W'(int'(tile_next) * STRIDE + int'(k_next));
            out_valid_next  = 1'b1;
            tile_start_next = (k_next == 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= FILL;
            col_reg        <= '0;
            row_reg        <= '0;
            band_reg       <= '0;
            base_reg       <= '0;
            tile_reg       <= '0;
            k_reg          <= '0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            tile_start_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            band_reg       <= band_next;
            base_reg       <= base_next;
            tile_reg       <= tile_next;
            k_reg          <= k_next;
            in_ready_reg   <= in_ready_next;
            out_valid_reg  <= out_valid_next;
            tile_start_reg <= tile_start_next;
            frame_done_reg <= frame_done_next;
            data_reg       <= data_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign r1_x       = data_reg[0];
    assign r2_x       = data_reg[1];
    assign r3_x       = data_reg[2];
    assign r4_x       = data_reg[3];
    assign out_valid  = out_valid_reg;
    assign tile_start = tile_start_reg;
    assign out_col    = k_reg;
    assign frame_done = frame_done_reg;
endmodule
